product_bcd: RTL and testbench

PRODUCT_BCD -- requirements
Module: product_bcd

---
 rtl/product_bcd_pkg.sv | 16 +
 rtl/product_bcd_add3.sv | 12 +
 rtl/product_bcd.sv | 89 ++++++++
 tb/tb_product_bcd.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_pkg.sv
// Shared definitions for the 8-bit binary to three-digit BCD converter.
// The widths, the iteration count and the FSM state encodings all live here.
package product_bcd_pkg;

  localparam int PRODUCT_W  = 8;
  localparam int DIGIT_W    = 4;
  localparam int ITER_COUNT = 8;
  localparam int SCRATCH_W  = 3 * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/product_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import product_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/product_bcd.sv
// Converts the multiplier product to hundreds/tens/units BCD digits by
// shift-add-3, one bit per cycle, started by a rising edge of i_DONE.
module product_bcd
  import product_bcd_pkg::*;
(
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic [PRODUCT_W-1:0] i_Y,
  input  logic                 i_DONE,
  output logic [DIGIT_W-1:0]   o_BCD_H,
  output logic [DIGIT_W-1:0]   o_BCD_T,
  output logic [DIGIT_W-1:0]   o_BCD_U,
  output logic                 o_VALID,
  output logic                 o_BUSY
);

  localparam logic [3:0] LAST_ITER = 4'(ITER_COUNT - 1);

  state_t                        state;
  state_t                        state_next;
  logic [3:0]                    count;
  logic [PRODUCT_W-1:0]          shift_reg;
  logic [SCRATCH_W-1:0]          scratch;
  logic [SCRATCH_W-1:0]          adjusted;
  logic [SCRATCH_W+PRODUCT_W-1:0] shifted;
  logic                          done_q;
  logic                          done_rise;
  logic                          last_iter;

  for (genvar d = 0; d < 3; d++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (scratch[d*DIGIT_W +: DIGIT_W]),
      .adjusted (adjusted[d*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted   = {adjusted, shift_reg} << 1;
  assign done_rise = i_DONE & ~done_q;
  assign last_iter = (count == LAST_ITER);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (done_rise) state_next = CONVERT;
      CONVERT: if (last_iter) state_next = PRESENT;
      PRESENT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Digits are loaded on the edge entering PRESENT so they appear together with o_VALID.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state     <= IDLE;
      count     <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      done_q    <= 1'b0;
      o_BCD_H   <= '0;
      o_BCD_T   <= '0;
      o_BCD_U   <= '0;
      o_VALID   <= 1'b0;
      o_BUSY    <= 1'b0;
    end else begin
      done_q  <= i_DONE;
      state   <= state_next;
      o_VALID <= (state_next == PRESENT);
      o_BUSY  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (done_rise) begin
            shift_reg <= i_Y;
            scratch   <= '0;
            count     <= '0;
          end
        end
        CONVERT: begin
          {scratch, shift_reg} <= shifted;
          count                <= count + 4'd1;
          if (last_iter) begin
            {o_BCD_H, o_BCD_T, o_BCD_U} <= shifted[SCRATCH_W+PRODUCT_W-1:PRODUCT_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd.sv
// Self-checking bench for product_bcd: directed corner cases, a full sweep and
// random products, all compared against plain decimal arithmetic.
module tb_product_bcd;

  logic       i_CLK;
  logic       i_RESET;
  logic [7:0] i_Y;
  logic       i_DONE;
  logic [3:0] o_BCD_H;
  logic [3:0] o_BCD_T;
  logic [3:0] o_BCD_U;
  logic       o_VALID;
  logic       o_BUSY;

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;

  product_bcd dut (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_Y     (i_Y),
    .i_DONE  (i_DONE),
    .o_BCD_H (o_BCD_H),
    .o_BCD_T (o_BCD_T),
    .o_BCD_U (o_BCD_U),
    .o_VALID (o_VALID),
    .o_BUSY  (o_BUSY)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Each o_VALID pulse is counted once, mid-cycle.
  always @(negedge i_CLK) if (o_VALID) valid_pulses++;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int digitOf(input int value, input int pos);
    int scaled = value;
    for (int i = 0; i < pos; i++) scaled = scaled / 10;
    return scaled % 10;
  endfunction

  task automatic checkDigits(input string tag, input int value);
    checkOutput({tag, "_h"}, int'(o_BCD_H), digitOf(value, 2));
    checkOutput({tag, "_t"}, int'(o_BCD_T), digitOf(value, 1));
    checkOutput({tag, "_u"}, int'(o_BCD_U), digitOf(value, 0));
  endtask

  // Starts one conversion from IDLE and checks latency, digits and pulse width.
  task automatic applyStimulus(input int value, input bit hold);
    int cyc;
    i_Y    = 8'(value);
    i_DONE = 1'b1;
    @(posedge i_CLK); #1;
    if (!hold) i_DONE = 1'b0;
    i_Y = 8'($urandom);
    cyc = 1;
    checkOutput("busy_start", int'(o_BUSY), 1);
    while (!o_VALID && cyc < 20) begin
      @(posedge i_CLK); #1;
      cyc++;
    end
    checkOutput("latency", cyc, 9);
    checkDigits("digits", value);
    @(posedge i_CLK); #1;
    checkOutput("valid_pulse", int'(o_VALID), 0);
    checkOutput("busy_end", int'(o_BUSY), 0);
    checkDigits("hold", value);
  endtask

  initial begin
    int pulses_before;
    int cyc;
    i_RESET = 1'b1;
    i_DONE  = 1'b0;
    i_Y     = 8'd0;
    #3 i_RESET = 1'b0;
    #1;
    checkOutput("rst_h", int'(o_BCD_H), 0);
    checkOutput("rst_t", int'(o_BCD_T), 0);
    checkOutput("rst_u", int'(o_BCD_U), 0);
    checkOutput("rst_valid", int'(o_VALID), 0);
    checkOutput("rst_busy", int'(o_BUSY), 0);
    repeat (3) @(posedge i_CLK);
    #1 i_RESET = 1'b1;
    @(posedge i_CLK); #1;

    applyStimulus(0, 1'b0);
    applyStimulus(255, 1'b0);
    applyStimulus(225, 1'b0);
    applyStimulus(144, 1'b0);

    $display("[TB] i_DONE held high");
    pulses_before = valid_pulses;
    applyStimulus(99, 1'b1);
    repeat (20) begin
      @(posedge i_CLK); #1;
      checkOutput("held_busy", int'(o_BUSY), 0);
    end
    checkOutput("held_pulses", valid_pulses - pulses_before, 1);
    checkDigits("held", 99);
    i_DONE = 1'b0;
    @(posedge i_CLK); #1;

    $display("[TB] rising edge while busy");
    pulses_before = valid_pulses;
    i_Y    = 8'd63;
    i_DONE = 1'b1;
    @(posedge i_CLK); #1;
    i_DONE = 1'b0;
    cyc = 1;
    while (cyc < 9) begin
      checkOutput("busy_mid", int'(o_BUSY), 1);
      @(posedge i_CLK); #1;
      cyc++;
      if (cyc == 4) begin
        i_Y    = 8'd7;
        i_DONE = 1'b1;
      end
    end
    checkOutput("busy_c9", int'(o_BUSY), 1);
    checkOutput("valid_c9", int'(o_VALID), 1);
    checkDigits("busy_edge", 63);
    repeat (5) @(posedge i_CLK);
    #1;
    checkOutput("busy_after", int'(o_BUSY), 0);
    checkOutput("busy_pulses", valid_pulses - pulses_before, 1);
    checkDigits("busy_hold", 63);
    i_DONE = 1'b0;
    @(posedge i_CLK); #1;

    $display("[TB] reset mid-conversion");
    i_Y    = 8'd200;
    i_DONE = 1'b1;
    @(posedge i_CLK); #1;
    i_DONE = 1'b0;
    repeat (4) @(posedge i_CLK);
    #2;
    pulses_before = valid_pulses;
    i_RESET = 1'b0;
    #1;
    checkOutput("abort_h", int'(o_BCD_H), 0);
    checkOutput("abort_t", int'(o_BCD_T), 0);
    checkOutput("abort_u", int'(o_BCD_U), 0);
    checkOutput("abort_valid", int'(o_VALID), 0);
    checkOutput("abort_busy", int'(o_BUSY), 0);
    i_DONE = 1'b1;
    repeat (6) @(posedge i_CLK);
    #1 i_RESET = 1'b1;
    checkOutput("abort_pulses", valid_pulses - pulses_before, 0);
    applyStimulus(200, 1'b0);

    $display("[TB] full sweep");
    for (int v = 0; v < 256; v++) begin
      applyStimulus(v, 1'b0);
    end

    $display("[TB] random products");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(0, 255)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
